// File: rtl/cpu_run_controller.sv
// cpu_run_controller: run/step/breakpoint sequencer for the 4-bit single-cycle CPU core.
// Paces execution to one instruction every PHASES cycles. It generates the execute strobe
// and the gated register-file write enable. It supports free-run, single-step and a single
// PC breakpoint.
// Optional feature: define CPU_CTRL_SELF_LOOP_HALT_EN to halt on a committed jump-to-self in RUN.
module cpu_run_controller #(
    parameter int unsigned PHASES = 3,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic             bp_valid,
    input  logic [3:0]       bp_addr,
    input  logic [3:0]       pc,
    input  logic [7:0]       instr,
    output logic             exec_en,
    output logic             rf_we,
    output logic [1:0]       state,
    output logic             halted_bp,
    output logic [CNT_W-1:0] instr_count,
    output logic             done
);

    localparam int unsigned     PH_W    = (PHASES > 1) ? $clog2(PHASES) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(PHASES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_STEP  = 2'b10,
        S_BREAK = 2'b11
    } state_t;

    state_t          cur;
    logic [PH_W-1:0] phase;
    logic [PH_W-1:0] phase_inc;
    logic            skip;
    logic            done_q;
    logic            active;
    logic            bp_hit;
    logic            self_loop;

    // Strobe and breakpoint decode from the current state and phase
    assign active    = (cur == S_RUN) || (cur == S_STEP);
    assign bp_hit    = (cur == S_RUN) && (phase == '0) && bp_valid && (pc == bp_addr) && !skip;
    assign exec_en   = active && (phase == PH_LAST) && !bp_hit;
    assign rf_we     = exec_en & ~instr[7];
    assign phase_inc = (phase == PH_LAST) ? '0 : phase + PH_W'(1);
    assign state     = cur;
    assign halted_bp = (cur == S_BREAK);

`ifdef CPU_CTRL_SELF_LOOP_HALT_EN
    logic unused_bits;
    // Jump-to-self: opcode class 2'b11 whose target equals the current PC
    assign self_loop   = (cur == S_RUN) && exec_en && (instr[7:6] == 2'b11) && (instr[3:0] == pc);
    assign done        = done_q;
    assign unused_bits = ^instr[5:4];
`else
    logic unused_bits;
    assign self_loop   = 1'b0;
    assign done        = 1'b0;
    assign unused_bits = ^{instr[6:0], done_q};
`endif

    // Run-control FSM with phase counter, resume-skip flag, retire counter and halt flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur         <= S_IDLE;
            phase       <= '0;
            skip        <= 1'b0;
            instr_count <= '0;
            done_q      <= 1'b0;
        end else begin
            if (exec_en) begin
                instr_count <= instr_count + CNT_W'(1);
            end
            case (cur)
                S_IDLE: begin
                    phase <= '0;
                    skip  <= 1'b0;
                    if (start) begin
                        cur    <= S_RUN;
                        done_q <= 1'b0;
                    end else if (step) begin
                        cur    <= S_STEP;
                        done_q <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (stop || self_loop) begin
                        // a strobe in this cycle still commits via instr_count above
                        cur   <= S_IDLE;
                        phase <= '0;
                        skip  <= 1'b0;
                        if (self_loop) begin
                            done_q <= 1'b1;
                        end
                    end else if (bp_hit) begin
                        cur   <= S_BREAK;
                        phase <= '0;
                        skip  <= 1'b0;
                    end else begin
                        phase <= phase_inc;
                        if (exec_en) begin
                            skip <= 1'b0;
                        end
                    end
                end
                S_STEP: begin
                    skip <= 1'b0;
                    if (stop || exec_en) begin
                        cur   <= S_IDLE;
                        phase <= '0;
                    end else begin
                        phase <= phase_inc;
                    end
                end
                S_BREAK: begin
                    phase <= '0;
                    if (stop) begin
                        cur  <= S_IDLE;
                        skip <= 1'b0;
                    end else if (start) begin
                        // skip lets the breakpointed instruction execute once on resume
                        cur  <= S_RUN;
                        skip <= 1'b1;
                    end else if (step) begin
                        cur  <= S_STEP;
                        skip <= 1'b0;
                    end
                end
                default: begin
                    cur   <= S_IDLE;
                    phase <= '0;
                    skip  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_controller.sv
// tb_cpu_run_controller: directed bench for cpu_run_controller.
// It uses a cycle-level model plus literal checks. A tiny core stand-in advances pc on each commit.
module tb_cpu_run_controller;

    localparam int PHASES = 3;
    localparam int CNT_W  = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             step = 1'b0;
    logic             bp_valid = 1'b0;
    logic [3:0]       bp_addr = 4'd0;
    logic [3:0]       pc = 4'd0;
    logic [7:0]       instr = 8'h05;
    logic             exec_en;
    logic             rf_we;
    logic [1:0]       state;
    logic             halted_bp;
    logic [CNT_W-1:0] instr_count;
    logic             done;

    logic             pc_jump = 1'b0;
    logic [3:0]       pc_jump_val = 4'd0;

    // model: mode uses the externally visible encoding, t = cycles since entering RUN/STEP
    int m_mode = 0;
    int m_t    = 0;
    int m_cnt  = 0;
    bit m_skip = 1'b0;
    bit m_done = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    cpu_run_controller #(.PHASES(PHASES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .step(step),
        .bp_valid(bp_valid), .bp_addr(bp_addr), .pc(pc), .instr(instr),
        .exec_en(exec_en), .rf_we(rf_we), .state(state), .halted_bp(halted_bp),
        .instr_count(instr_count), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_hit();
        return (m_mode == 1) && ((m_t % PHASES) == 0) && bp_valid && (pc == bp_addr) && !m_skip;
    endfunction

    function automatic bit m_ex();
        return ((m_mode == 1) || (m_mode == 2)) && ((m_t % PHASES) == PHASES - 1) && !m_hit();
    endfunction

    // Model update and core stand-in
    initial begin : model
        bit ex;
        bit hit;
        bit sl;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_mode = 0; m_t = 0; m_skip = 1'b0; m_cnt = 0; m_done = 1'b0;
                pc <= 4'd0;
            end else begin
                ex  = m_ex();
                hit = m_hit();
                sl  = 1'b0;
`ifdef CPU_CTRL_SELF_LOOP_HALT_EN
                sl = (m_mode == 1) && ex && (instr[7:6] == 2'b11) && (instr[3:0] == pc);
`endif
                if (ex) m_cnt = (m_cnt + 1) % (1 << CNT_W);
                case (m_mode)
                    0: begin
                        if (start)     begin m_mode = 1; m_t = 0; m_done = 1'b0; end
                        else if (step) begin m_mode = 2; m_t = 0; m_done = 1'b0; end
                    end
                    1: begin
                        if (stop || sl) begin
                            m_mode = 0; m_skip = 1'b0;
                            if (sl) m_done = 1'b1;
                        end else if (hit) begin
                            m_mode = 3; m_skip = 1'b0;
                        end else begin
                            m_t++;
                            if (ex) m_skip = 1'b0;
                        end
                    end
                    2: begin
                        if (stop || ex) m_mode = 0;
                        else m_t++;
                    end
                    default: begin
                        if (stop)       m_mode = 0;
                        else if (start) begin m_mode = 1; m_t = 0; m_skip = 1'b1; end
                        else if (step)  begin m_mode = 2; m_t = 0; end
                    end
                endcase
                if (pc_jump) pc <= pc_jump_val;
                else if (ex) pc <= (instr[7:6] == 2'b11) ? instr[3:0] : pc + 4'd1;
            end
        end
    end

    // Per-cycle comparison against the model
    initial begin : compare
        bit ex;
        forever begin
            @(negedge clk);
            ex = m_ex();
            chk("exec_en", int'(exec_en), int'(ex));
            chk("rf_we", int'(rf_we), int'(ex && !instr[7]));
            chk("state", int'(state), m_mode);
            chk("halted_bp", int'(halted_bp), int'(m_mode == 3));
            chk("instr_count", int'(instr_count), m_cnt);
            chk("done", int'(done), int'(m_done));
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        #4;
    endtask

    initial begin : stim
        int seen;
        int hits;
        int k;
        tick(); tick();
        at_neg();
        chk("rst_state", int'(state), 0);
        chk("rst_count", int'(instr_count), 0);
        chk("rst_exec", int'(exec_en), 0);
        tick(); rst = 1'b0;
        tick();

        // free run, 9 cycles
        start = 1'b1; tick(); start = 1'b0;
        seen = 0;
        for (int i = 1; i <= 9; i++) begin
            at_neg();
            if (exec_en) seen |= (1 << (i - 1));
            tick();
        end
        chk("run_strobe_cycles", seen, 'h124);
        chk("run_count", int'(instr_count), 3);
        chk("run_pc", int'(pc), 3);
        stop = 1'b1; tick(); stop = 1'b0;
        chk("stop_idle", int'(state), 0);

        // single step
        instr = 8'h05;
        step = 1'b1; tick(); step = 1'b0;
        hits = 0; seen = 0; k = 0;
        for (int i = 1; i <= 4; i++) begin
            at_neg();
            if (exec_en) begin hits++; seen = i; k = int'(rf_we); end
            tick();
        end
        chk("step_commits", hits, 1);
        chk("step_cycle", seen, 3);
        chk("step_rf_we", k, 1);
        chk("step_idle", int'(state), 0);
        chk("step_count", int'(instr_count), 4);

        // breakpoint at pc=4
        pc_jump = 1'b1; pc_jump_val = 4'd0; tick(); pc_jump = 1'b0;
        bp_valid = 1'b1; bp_addr = 4'd4;
        start = 1'b1; tick(); start = 1'b0;
        hits = 0; k = 0;
        while (state != 2'b11 && k < 40) begin
            if (exec_en && pc == 4'd4) hits++;
            tick();
            k++;
        end
        chk("bp_reached", int'(state), 3);
        chk("bp_pc", int'(pc), 4);
        chk("bp_halted", int'(halted_bp), 1);
        chk("bp_no_exec_at_4", hits, 0);
        chk("bp_count", int'(instr_count), 8);
        tick();
        chk("bp_hold_exec", int'(exec_en), 0);
        chk("bp_hold_state", int'(state), 3);

        // resume: pc=4 commits once, stop lands in its strobe cycle
        start = 1'b1; tick(); start = 1'b0;
        hits = 0; seen = 0;
        for (int i = 1; i <= 3; i++) begin
            at_neg();
            if (state == 2'b11) hits++;
            if (exec_en) seen = i;
            if (i == 3) stop = 1'b1;
            tick();
        end
        stop = 1'b0;
        chk("resume_no_rebreak", hits, 0);
        chk("resume_exec_cycle", seen, 3);
        chk("stop_in_exec_count", int'(instr_count), 9);
        chk("stop_in_exec_idle", int'(state), 0);
        chk("resume_pc", int'(pc), 5);

        // start+stop together in BREAK
        bp_addr = 4'd5;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        chk("bp2_break", int'(state), 3);
        start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
        chk("start_stop_break", int'(state), 0);
        chk("bp2_count", int'(instr_count), 9);

        // jump-to-self at pc=7
        bp_valid = 1'b0;
        pc_jump = 1'b1; pc_jump_val = 4'd7; tick(); pc_jump = 1'b0;
        instr = 8'hC7;
        start = 1'b1; tick(); start = 1'b0;
        repeat (6) tick();
`ifdef CPU_CTRL_SELF_LOOP_HALT_EN
        chk("selfloop_state", int'(state), 0);
        chk("selfloop_done", int'(done), 1);
        chk("selfloop_count", int'(instr_count), 10);
`else
        chk("selfloop_state", int'(state), 1);
        chk("selfloop_done", int'(done), 0);
        chk("selfloop_count", int'(instr_count), 11);
`endif
        chk("selfloop_pc", int'(pc), 7);
        stop = 1'b1; tick(); stop = 1'b0;

        // held step retriggers from IDLE; accepted step clears done
        instr = 8'h85;
        step = 1'b1; repeat (8) tick(); step = 1'b0;
        repeat (4) tick();
        chk("held_step_idle", int'(state), 0);
        chk("step_clears_done", int'(done), 0);

        // asynchronous reset at phase 1 of RUN
        instr = 8'h05;
        start = 1'b1; tick(); start = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_state", int'(state), 0);
        chk("arst_count", int'(instr_count), 0);
        chk("arst_exec", int'(exec_en), 0);
        tick(); rst = 1'b0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
Run/step/breakpoint sequencer for the 4-bit single-cycle CPU core.
- Paces instruction execution to one instruction every PHASES cycles.
- Produces the execute strobe that gates the program-counter load, and a gated register-file write enable.
- Supports free-run, single-step and one PC breakpoint, for bring-up and debug of the core.

Parameters:
PHASES, 3, clock cycles per instruction (>=1); execute strobe in the last phase
CNT_W, 8, width of the retired-instruction counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  pulse: enter free-run
stop  input  1  pulse: return to idle
step  input  1  pulse: execute exactly one instruction
bp_valid  input  1  breakpoint enable
bp_addr  input  4  breakpoint PC
pc  input  4  current program counter of the core
instr  input  8  current instruction-memory output
exec_en  output  1  PC load / instruction commit strobe (combinational)
rf_we  output  1  register-file write enable = exec_en & ~instr[7]
state  output  2  00 IDLE, 01 RUN, 10 STEP, 11 BREAK
halted_bp  output  1  high while in BREAK
instr_count  output  CNT_W  retired instructions, wraps at 2^CNT_W
done  output  1  self-loop halt flag (see Optional Feature)

Behaviour:
Reset (async, rst=1):
- state=IDLE, phase=0, skip=0, instr_count=0, done=0.
- exec_en=0, rf_we=0, halted_bp=0.

Phase counter (0..PHASES-1):
- Cleared on every entry to RUN or STEP.
- Increments in RUN/STEP; wraps to 0 after PHASES-1.
- Held at 0 in IDLE/BREAK.

bp_hit (combinational) = state==RUN & phase==0 & bp_valid & pc==bp_addr & ~skip.

exec_en (combinational) = (state==RUN | state==STEP) & phase==PHASES-1 & ~bp_hit.
- With PHASES=1, bp_hit suppresses the same-cycle strobe.

instr_count: +1 at each clock edge where exec_en=1; wraps modulo 2^CNT_W.

FSM transitions (priority top-down within each state):
IDLE:
- start → RUN.
- else step → STEP.
- start+step in the same cycle → RUN.
RUN:
- stop → IDLE.
  - If stop arrives in an exec_en cycle, that instruction still commits.
- else bp_hit → BREAK; the instruction at bp_addr is not executed.
- else stay.
STEP:
- At the edge where exec_en=1 → IDLE.
- stop before that edge → IDLE with no commit.
- start and step are ignored.
BREAK:
- stop → IDLE.
- else start → RUN with skip=1.
- else step → STEP.
- start+stop in the same cycle → IDLE.

skip:
- Set on BREAK→RUN.
- Cleared at the first exec_en edge, or on leaving RUN.
- Ensures the breakpointed instruction executes once on resume.

Other rules:
- Breakpoints are not checked in STEP.
- start/step pulses held longer than one cycle are level-tolerant: a re-trigger occurs only after returning to IDLE or BREAK.
- pc and instr are treated as stable for the whole instruction (the core updates pc only on exec_en).
- Reset mid-instruction aborts immediately; no commit.

Optional Feature:
Macro CPU_CTRL_SELF_LOOP_HALT_EN.
- Defined:
  - An exec_en cycle in RUN with instr[7:6]==2'b11 and instr[3:0]==pc (jump-to-self) commits.
  - Then state→IDLE and done is set to 1.
  - done clears on the next start or step accepted from IDLE.
- Undefined:
  - done is tied 0.
  - Jump-to-self loops forever in RUN until stop.

Test Plan:
- Reset mid-RUN at phase 1 → state=00, instr_count=0, exec_en=0 in the same cycle (async).
- PHASES=3, start, run 9 cycles, bp_valid=0 → exec_en high on cycles 3, 6, 9 after entry; instr_count=3.
- IDLE, step pulse, instr=8'h05 → exactly one exec_en after 3 cycles, rf_we=1, then state=00.
- RUN with bp_valid=1, bp_addr=4, pc reaches 4 → state=11, halted_bp=1, no exec_en at pc=4; start → pc=4 instruction commits once, no re-break, pc advances.
- stop asserted in the exec_en cycle of RUN → that commit counted (instr_count+1), state=00 next cycle; start+stop in BREAK → state=00.
- With CPU_CTRL_SELF_LOOP_HALT_EN and instr=8'hC7 at pc=7 → one commit, then state=00, done=1. Without the macro: RUN continues and done=0.
